// File: rtl/des_decrypt_core.sv
// des_decrypt_core: iterative DES core, one round per cycle using an external round function.
// Defining DES_ENCRYPT_MODE_EN adds a mode input (1 = encrypt, 0 = decrypt).
module des_decrypt_core (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
`ifdef DES_ENCRYPT_MODE_EN
    input  logic        mode,
`endif
    input  logic [63:0] data_in,
    input  logic [63:0] key_in,
    input  logic [31:0] f_result,
    output logic [31:0] f_right,
    output logic [47:0] f_subkey,
    output logic        busy,
    output logic        done,
    output logic [63:0] data_out
);
    localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, ROUND = 2'd2, FINISH = 2'd3;
    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17, 9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
    localparam int FP_T [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41, 9, 49, 17, 57, 25};
    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
        10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
        14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};
    localparam int PC2_T [48] = '{
        14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10,
        23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    function automatic logic [63:0] ip(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) y[63-i] = x[64-IP_T[i]];
        return y;
    endfunction

    function automatic logic [63:0] fp(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) y[63-i] = x[64-FP_T[i]];
        return y;
    endfunction

    function automatic logic [55:0] pc1(input logic [63:0] x);
        logic [55:0] y;
        for (int i = 0; i < 56; i++) y[55-i] = x[64-PC1_T[i]];
        return y;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] x);
        logic [47:0] y;
        for (int i = 0; i < 48; i++) y[47-i] = x[56-PC2_T[i]];
        return y;
    endfunction

    function automatic logic [27:0] rot(input logic [27:0] x, input logic left, input logic one);
        return left ? (one ? {x[26:0], x[27]} : {x[25:0], x[27:26]})
                    : (one ? {x[0], x[27:1]} : {x[1:0], x[27:2]});
    endfunction

    logic [1:0]  state_q, state_d;
    logic [63:0] data_q, data_d, key_q, key_d, out_q, out_d;
    logic [31:0] l_q, l_d, r_q, r_d;
    logic [27:0] c_q, c_d, d_q, d_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        done_q, done_d, mode_q, mode_d, mode_in, rot_one;
    logic [55:0] pc1_key;

`ifdef DES_ENCRYPT_MODE_EN
    assign mode_in = mode;
`else
    assign mode_in = 1'b0;
`endif

    assign pc1_key  = pc1(key_q);
    assign rot_one  = cnt_q == 4'd0 || cnt_q == 4'd7 || cnt_q == 4'd14;
    assign f_right  = r_q;
    assign f_subkey = pc2({c_q, d_q});
    assign busy     = state_q == LOAD || state_q == ROUND;
    assign done     = done_q;
    assign data_out = out_q;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        key_d   = key_q;
        mode_d  = mode_q;
        l_d     = l_q;
        r_d     = r_q;
        c_d     = c_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                data_d  = data_in;
                key_d   = key_in;
                mode_d  = mode_in;
                state_d = LOAD;
            end
            LOAD: begin
                {l_d, r_d} = ip(data_q);
                // encryption pre-rotates so round 0 already sees K1
                c_d     = mode_q ? rot(pc1_key[55:28], 1'b1, 1'b1) : pc1_key[55:28];
                d_d     = mode_q ? rot(pc1_key[27:0], 1'b1, 1'b1) : pc1_key[27:0];
                cnt_d   = 4'd0;
                state_d = ROUND;
            end
            ROUND: begin
                l_d     = r_q;
                r_d     = l_q ^ f_result;
                cnt_d   = cnt_q + 4'd1;
                c_d     = cnt_q == 4'd15 ? c_q : rot(c_q, mode_q, rot_one);
                d_d     = cnt_q == 4'd15 ? d_q : rot(d_q, mode_q, rot_one);
                state_d = cnt_q == 4'd15 ? FINISH : ROUND;
            end
            default: begin
                out_d   = fp({r_q, l_q});
                done_d  = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            key_q   <= '0;
            mode_q  <= 1'b0;
            l_q     <= '0;
            r_q     <= '0;
            c_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            key_q   <= key_d;
            mode_q  <= mode_d;
            l_q     <= l_d;
            r_q     <= r_d;
            c_q     <= c_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            done_q  <= done_d;
        end
    end
endmodule

// File: tb/tb_des_decrypt_core.sv
// tb_des_decrypt_core: directed and random checks of des_decrypt_core against a software DES model.
module tb_des_decrypt_core;
    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17, 9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
        10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
        14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};
    localparam int PC2_T [48] = '{
        14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10,
        23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
    localparam int E_T [48] = '{
        32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9, 10, 11, 12, 13,
        12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1};
    localparam int P_T [32] = '{
        16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
        2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
    localparam int SB [512] = '{
        14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
        0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
        4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
        15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13,
        15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,
        3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
        0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,
        13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9,
        10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,
        13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
        13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,
        1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12,
        7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,
        13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
        10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,
        3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14,
        2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
        14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
        4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
        11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3,
        12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,
        10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
        9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,
        4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13,
        4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,
        13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
        1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,
        6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12,
        13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,
        1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
        7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,
        2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11};

    logic        clk, rst, start, mode_r, busy, done;
    logic [63:0] data_in, key_in, data_out;
    logic [31:0] f_result, f_right;
    logic [47:0] f_subkey;
    int          total = 0, bad = 0, cyc = 0;

    des_decrypt_core dut (
        .clk(clk),
        .rst(rst),
        .start(start),
`ifdef DES_ENCRYPT_MODE_EN
        .mode(mode_r),
`endif
        .data_in(data_in),
        .key_in(key_in),
        .f_result(f_result),
        .f_right(f_right),
        .f_subkey(f_subkey),
        .busy(busy),
        .done(done),
        .data_out(data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] ip_m(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) y[63-i] = x[64-IP_T[i]];
        return y;
    endfunction

    // final permutation is the inverse of IP
    function automatic logic [63:0] fp_m(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) y[64-IP_T[i]] = x[63-i];
        return y;
    endfunction

    function automatic logic [47:0] subkey_m(input logic [63:0] k, input int n);
        logic [55:0] cd;
        logic [27:0] c, d;
        logic [47:0] y;
        for (int i = 0; i < 56; i++) cd[55-i] = k[64-PC1_T[i]];
        c = cd[55:28];
        d = cd[27:0];
        for (int j = 0; j <= n; j++)
            for (int s = 0; s < ((j == 0 || j == 1 || j == 8 || j == 15) ? 1 : 2); s++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
        cd = {c, d};
        for (int i = 0; i < 48; i++) y[47-i] = cd[56-PC2_T[i]];
        return y;
    endfunction

    function automatic logic [31:0] f_m(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] x;
        logic [31:0] so, y;
        logic [5:0]  six;
        for (int i = 0; i < 48; i++) x[47-i] = r[32-E_T[i]];
        x = x ^ k;
        for (int s = 0; s < 8; s++) begin
            six = x[47-6*s -: 6];
            so[31-4*s -: 4] = 4'(SB[s*64 + 16*int'({six[5], six[0]}) + int'(six[4:1])]);
        end
        for (int i = 0; i < 32; i++) y[31-i] = so[32-P_T[i]];
        return y;
    endfunction

    function automatic logic [63:0] des_m(input logic [63:0] b, input logic [63:0] k, input logic enc);
        logic [63:0] lr;
        logic [31:0] l, r, t;
        lr = ip_m(b);
        l = lr[63:32];
        r = lr[31:0];
        for (int i = 0; i < 16; i++) begin
            t = r;
            r = l ^ f_m(r, subkey_m(k, enc ? i : 15 - i));
            l = t;
        end
        return fp_m({r, l});
    endfunction

    assign f_result = f_m(f_right, f_subkey);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // called on a negedge; returns at the negedge where done is first seen
    task automatic run(input logic [63:0] d, input logic [63:0] k, input logic enc,
                       output logic [47:0] sk0, output int dcyc);
        logic [63:0] exp_v, ipd;
        int lat;
        exp_v = des_m(d, k, enc);
        ipd = ip_m(d);
        sk0 = '0;
        start = 1'b1; data_in = d; key_in = k; mode_r = enc;
        @(negedge clk);
        start = 1'b0; data_in = {$urandom, $urandom}; key_in = {$urandom, $urandom}; mode_r = ~enc;
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                sk0 = f_subkey;
                chk("round0_subkey", 64'(f_subkey), 64'(subkey_m(k, enc ? 0 : 15)));
                chk("round0_right", 64'(f_right), 64'(ipd[31:0]));
                chk("busy_in_round", 64'(busy), 64'd1);
            end
        end
        chk("latency", 64'(lat), 64'd18);
        chk("result", data_out, exp_v);
        dcyc = cyc;
    endtask

    initial begin
        logic [47:0] sk;
        logic [63:0] d, exp_v;
        int t0, t1, n, lat;
        rst = 1'b1; start = 1'b0; mode_r = 1'b0;
        data_in = {$urandom, $urandom}; key_in = {$urandom, $urandom};
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_data_out", data_out, 64'd0);
        chk("rst_f_right", 64'(f_right), 64'd0);
        chk("rst_f_subkey", 64'(f_subkey), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        run(64'h85E813540F0AB405, 64'h133457799BBCDFF1, 1'b0, sk, t0);
        chk("kat1_result", data_out, 64'h0123456789ABCDEF);
        chk("kat1_k16", 64'(sk), 64'hCB3D8B0E17F5);
        @(negedge clk);
        chk("done_pulse_width", 64'(done), 64'd0);
        chk("data_out_hold", data_out, 64'h0123456789ABCDEF);
        run(64'h95F8A5E5DD31D900, 64'h0101010101010101, 1'b0, sk, t0);
        chk("kat2_result", data_out, 64'h8000000000000000);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            run({$urandom, $urandom}, {$urandom, $urandom}, 1'b0, sk, t0);
        end

        // abort at round 7 with an asynchronous reset
        @(negedge clk);
        start = 1'b1; data_in = 64'h85E813540F0AB405; key_in = 64'h133457799BBCDFF1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_data_out", data_out, 64'd0);
        chk("abort_f_right", 64'(f_right), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        repeat (25) begin
            @(negedge clk);
            if (done) n++;
        end
        chk("abort_no_done", 64'(n), 64'd0);
        chk("abort_data_out_later", data_out, 64'd0);
        run(64'h85E813540F0AB405, 64'h133457799BBCDFF1, 1'b0, sk, t0);
        chk("restart_result", data_out, 64'h0123456789ABCDEF);

        // start held high with changing data during a block
        @(negedge clk);
        d = {$urandom, $urandom};
        key_in = {$urandom, $urandom};
        exp_v = des_m(d, key_in, 1'b0);
        start = 1'b1; data_in = d;
        @(negedge clk);
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            start = 1'b1; data_in = {$urandom, $urandom}; key_in = {$urandom, $urandom};
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        chk("storm_latency", 64'(lat), 64'd18);
        chk("storm_result", data_out, exp_v);
        n = 0;
        repeat (25) begin
            @(negedge clk);
            if (done) n++;
        end
        chk("storm_single_done", 64'(n), 64'd0);
        chk("storm_idle", 64'(busy), 64'd0);

        // back-to-back blocks
        run({$urandom, $urandom}, {$urandom, $urandom}, 1'b0, sk, t0);
        run({$urandom, $urandom}, {$urandom, $urandom}, 1'b0, sk, t1);
        chk("b2b_gap", 64'(t1 - t0), 64'd19);

`ifdef DES_ENCRYPT_MODE_EN
        @(negedge clk);
        run(64'h0123456789ABCDEF, 64'h133457799BBCDFF1, 1'b1, sk, t0);
        chk("enc_kat", data_out, 64'h85E813540F0AB405);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            run({$urandom, $urandom}, {$urandom, $urandom}, 1'b1, sk, t0);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
